// File: rtl/booth2_pkg.sv
// -----------------------------------------------------------------------------
// booth2_pkg
// Shared constants, types and helpers for the Booth radix-4 partial-product
// accumulator and its alignment stage.
//   PP_NUM     : partial products per multiplication
//   PP_W       : width of one unshifted partial product (two's complement)
//   OUT_W      : product width
//   SHIFT_STEP : bit distance between consecutive partial-product weights
// -----------------------------------------------------------------------------
package booth2_pkg;

    localparam int PP_NUM     = 8;
    localparam int PP_W       = 18;
    localparam int OUT_W      = 32;
    localparam int SHIFT_STEP = 2;

    // Counter selecting the partial product being added.
    localparam int CNT_W = $clog2(PP_NUM);

    typedef logic [PP_W-1:0] pp_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Sign-extend a partial product to the full product width.
    function automatic logic [OUT_W-1:0] sext32(input pp_word pp);
        return {{(OUT_W-PP_W){pp[PP_W-1]}}, pp};
    endfunction

endpackage

// File: rtl/booth2_pp_align.sv
// -----------------------------------------------------------------------------
// booth2_pp_align
// Combinational alignment of one Booth partial product: sign-extend to OUT_W
// bits and shift left by SHIFT_STEP*index so it carries its radix-4 weight.
// Ports:
//   pp_i      : unshifted partial product (two's complement)
//   idx_i     : partial-product index (0 = weight 2^0)
//   aligned_o : sign-extended, weighted partial product
// -----------------------------------------------------------------------------
module booth2_pp_align
    import booth2_pkg::*;
(
    input  logic [PP_W-1:0]  pp_i,
    input  logic [CNT_W-1:0] idx_i,
    output logic [OUT_W-1:0] aligned_o
);

    localparam int SHAMT_W = $clog2(OUT_W);

    logic [SHAMT_W-1:0] shamt;

    assign shamt     = SHAMT_W'(idx_i) * SHAMT_W'(SHIFT_STEP);
    // Sign extension happens before the shift so bits shifted past OUT_W
    // are simply dropped (sum is mod 2^OUT_W).
    assign aligned_o = sext32(pp_i) << shamt;

endmodule

// File: rtl/booth2_pp_accumulator.sv
// -----------------------------------------------------------------------------
// booth2_pp_accumulator
// Sequential consumer of a Booth radix-4 partial-product set for a 16x16
// signed multiply. One set of eight unshifted partial products is captured
// through a valid/ready handshake, then one aligned partial product is added
// per clock. The 32-bit product is offered on a valid/ready output.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   in_valid/in_ready: input handshake for PP1..PP8
//   PP1..PP8         : partial products, weights 2^0 .. 2^14
//   out_valid/out_ready: output handshake for product
//   product          : signed product, held stable while out_valid
//   busy             : accumulation in progress
// -----------------------------------------------------------------------------
module booth2_pp_accumulator
    import booth2_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP_W-1:0]   PP1,
    input  logic [PP_W-1:0]   PP2,
    input  logic [PP_W-1:0]   PP3,
    input  logic [PP_W-1:0]   PP4,
    input  logic [PP_W-1:0]   PP5,
    input  logic [PP_W-1:0]   PP6,
    input  logic [PP_W-1:0]   PP7,
    input  logic [PP_W-1:0]   PP8,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  product,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PP_NUM - 1);

    state_e             state_q;
    logic [OUT_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    pp_word             pp_q  [PP_NUM];
    pp_word             pp_in [PP_NUM];

    logic               accept;
    logic [OUT_W-1:0]   aligned;
    logic [OUT_W-1:0]   sum_d;

    assign pp_in[0] = PP1;
    assign pp_in[1] = PP2;
    assign pp_in[2] = PP3;
    assign pp_in[3] = PP4;
    assign pp_in[4] = PP5;
    assign pp_in[5] = PP6;
    assign pp_in[6] = PP7;
    assign pp_in[7] = PP8;

    // Ready is gated by reset directly so no set can be taken while reset is
    // held, and rises in the first cycle after reset is released.
    assign in_ready = (state_q == IDLE) && !sys_rst;
    assign accept   = in_valid && in_ready;

    // Capture registers: inputs may change freely once the set is taken.
    genvar gi;
    generate
        for (gi = 0; gi < PP_NUM; gi++) begin : g_pp_reg
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    pp_q[gi] <= '0;
                end else if (accept) begin
                    pp_q[gi] <= pp_in[gi];
                end
            end
        end
    endgenerate

    booth2_pp_align u_align (
        .pp_i      (pp_q[cnt_q]),
        .idx_i     (cnt_q),
        .aligned_o (aligned)
    );

    assign sum_d = acc_q + aligned;

    // Control FSM with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            product   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ACC;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                ACC: begin
                    acc_q <= sum_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // The last add lands directly in the product register so
                    // out_valid rises PP_NUM clocks after the accepting edge.
                    if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        out_valid <= 1'b1;
                        product   <= sum_d;
                        busy      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth2_pp_accumulator.sv
// -----------------------------------------------------------------------------
// tb_booth2_pp_accumulator
// Directed and random stimulus for the Booth radix-4 partial-product
// accumulator. Partial products are produced by a local radix-4 Booth
// encoder; expected products are the plain signed multiply of the operands,
// queued at acceptance and popped at the output handshake.
// -----------------------------------------------------------------------------
module tb_booth2_pp_accumulator;

    logic         sys_clk   = 1'b0;
    logic         sys_rst   = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [31:0]  product;
    logic [143:0] pp_bus    = '0;

    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  sb [$];

    always #5 sys_clk = ~sys_clk;

    booth2_pp_accumulator dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .PP1       (pp_bus[17:0]),
        .PP2       (pp_bus[35:18]),
        .PP3       (pp_bus[53:36]),
        .PP4       (pp_bus[71:54]),
        .PP5       (pp_bus[89:72]),
        .PP6       (pp_bus[107:90]),
        .PP7       (pp_bus[125:108]),
        .PP8       (pp_bus[143:126]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Radix-4 Booth encoding of B applied to multiplicand A.
    function automatic logic [143:0] booth_pps(input logic [15:0] a, input logic [15:0] b);
        logic [143:0]       r;
        logic [16:0]        bx;
        logic [2:0]         g;
        logic signed [17:0] m;
        logic signed [17:0] d;
        r  = '0;
        bx = {b, 1'b0};
        m  = {{2{a[15]}}, a};
        for (int i = 0; i < 8; i++) begin
            g = bx[2*i +: 3];
            case (g)
                3'b000, 3'b111: d = '0;
                3'b001, 3'b010: d = m;
                3'b011:         d = m <<< 1;
                3'b100:         d = -(m <<< 1);
                default:        d = -m;
            endcase
            r[18*i +: 18] = d;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation: accept, accumulate, hold for `stall` cycles in DONE
    // (pulsing in_valid, which must be ignored), then hand the product off.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int stall, input string tag);
        int          lat;
        logic [31:0] held;
        logic [31:0] exp_p;
        pp_bus   = booth_pps(a, b);
        in_valid = 1'b1;
        check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        sb.push_back(32'($signed(a)) * 32'($signed(b)));
        in_valid = 1'b0;
        pp_bus   = {16'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
        check({tag, ":busy_acc"}, 32'(busy), 32'd1);
        check({tag, ":in_ready_acc"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'd8);
        check({tag, ":busy_done"}, 32'(busy), 32'd0);
        held = product;
        for (int s = 0; s < stall; s++) begin
            in_valid = ~in_valid;
            tick();
            check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ":hold_product"}, product, held);
            check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_p = (sb.size() != 0) ? sb.pop_front() : 32'hDEADBEEF;
        check({tag, ":product"}, product, exp_p);
        tick();
        out_ready = 1'b0;
        check({tag, ":out_valid_clear"}, 32'(out_valid), 32'd0);
        check({tag, ":in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          rises;
        logic [15:0] ra;
        logic [15:0] rb;

        // Reset with in_valid asserted: nothing may be captured.
        pp_bus   = booth_pps(16'd3, 16'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst:in_ready", 32'(in_ready), 32'd0);
        end
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:product", product, 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        sys_rst  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst:in_ready_after", 32'(in_ready), 32'd1);
        tick();
        check("rst:no_capture", 32'(in_ready), 32'd1);
        check("rst:busy_after", 32'(busy), 32'd0);

        // Directed sets.
        do_op(16'd3,      16'd5,      0, "a3b5");
        check("a3b5:const", 32'(32'd3 * 32'd5), 32'h0000000F);
        do_op(16'hFFFF,   16'd2,      1, "am1b2");
        do_op(16'h8000,   16'h8000,   0, "minmin");

        // Backpressure: five stalled cycles with in_valid pulses.
        do_op(16'h1234,   16'hF00D,   5, "bp");

        // Reset four clocks after accept aborts the operation.
        pp_bus   = booth_pps(16'd3, 16'd5);
        in_valid = 1'b1;
        tick();
        sb.push_back(32'd15);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        sys_rst = 1'b1;
        tick();
        check("abort:out_valid", 32'(out_valid), 32'd0);
        check("abort:product", product, 32'd0);
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:in_ready", 32'(in_ready), 32'd0);
        void'(sb.pop_back());
        sys_rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) rises++;
        end
        check("abort:no_out_valid", 32'(rises), 32'd0);
        check("abort:product_zero", product, 32'd0);
        do_op(16'd3, 16'd5, 0, "post_abort");

        // Corners and random operands with random output stalls.
        do_op(16'h7FFF, 16'h7FFF, 2, "maxmax");
        do_op(16'h8000, 16'h7FFF, 0, "minmax");
        do_op(16'hFFFF, 16'hFFFF, 0, "m1m1");
        do_op(16'd0,    16'h8000, 1, "zero");
        for (int k = 0; k < 400; k++) begin
            ra = 16'($urandom());
            rb = 16'($urandom());
            do_op(ra, rb, int'($urandom_range(0, 3)), "rand");
        end

        check("sb:empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
